ppa_sub_7: RTL and testbench

- Pipelined 7-bit subtractor for the core ALU: D = a - b - bin.
- Computes the borrow chain with a parallel-prefix network (P/G on a and ~b, carry-in = ~bin), split across two register stages.
- Valid/ready handshake on both sides so it can sit between the operand-fetch and writeback stages with backpressure.
- Also reports unsigned-borrow, zero and signed-overflow flags for compare and branch use.

---
 rtl/ppa_sub_7_if.sv | 30 +++
 rtl/ppa_sub_7.sv | 136 +++++++++++++
 tb/tb_ppa_sub_7.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/ppa_sub_7_if.sv
// Handshake/data bundle for the ppa_sub_7 pipelined subtractor.
// The master drives operands and out_ready. The slave (the subtractor) drives
// in_ready and the registered result fields.
//   in_valid/in_ready/a/b/bin          : operand channel
//   out_valid/out_ready/d/bout/zero/ovf : result channel
interface ppa_sub_7_if #(
  parameter int unsigned WIDTH = 7
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] d;
  logic             bout;
  logic             zero;
  logic             ovf;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, d, bout, zero, ovf
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, d, bout, zero, ovf
  );
endinterface

// File: rtl/ppa_sub_7.sv
// Two-stage pipelined subtractor: d = (a - b - bin) mod 2^WIDTH.
// The borrow chain is a Kogge-Stone prefix tree over (a, ~b) with carry-in ~bin.
// Stage 1 registers bitwise p/g and the first prefix level. Stage 2 finishes the
// tree and registers d, bout, zero and ovf.
// Ports:
//   clk : clock, rising edge
//   rst : synchronous active-high reset; empties both stages
//   bus : ppa_sub_7_if slave (operand and result valid/ready channels)
module ppa_sub_7 #(
  parameter int unsigned WIDTH = 7
) (
  input  logic         clk,
  input  logic         rst,
  ppa_sub_7_if.slave   bus
);

  // The carry-in sits at extended index 0, so bit j of the operands is index j+1.
  localparam int unsigned W1 = WIDTH + 1;

  // One Kogge-Stone level: combine each node with the node `span` positions below.
  function automatic logic [2*W1-1:0] ks_level(input logic [W1-1:0] g,
                                               input logic [W1-1:0] p,
                                               input int unsigned   span);
    logic [W1-1:0] g_n;
    logic [W1-1:0] p_n;
    g_n = g;
    p_n = p;
    for (int unsigned i = span; i < W1; i++) begin
      g_n[i] = g[i] | (p[i] & g[i-span]);
      p_n[i] = p[i] & p[i-span];
    end
    return {g_n, p_n};
  endfunction

  logic s1_valid_q, s2_valid_q;
  logic s2_load, s1_load;
  logic in_ready;

  // Stage 1 state.
  logic [WIDTH-1:0] s1_p_q,  s1_p_d;
  logic [W1-1:0]    s1_g_q,  s1_g_d;
  logic [W1-1:0]    s1_pp_q, s1_pp_d;
  logic             s1_a_msb_q, s1_b_msb_q;

  // Stage 2 state.
  logic [WIDTH-1:0] s2_d_q,    s2_d_d;
  logic             s2_bout_q, s2_bout_d;
  logic             s2_zero_q, s2_zero_d;
  logic             s2_ovf_q,  s2_ovf_d;

  // Handshake / advance control.
  always_comb begin
    s2_load  = s1_valid_q & (~s2_valid_q | bus.out_ready);
    in_ready = ~s1_valid_q | s2_load;
    s1_load  = bus.in_valid & in_ready;
  end

  // Stage 1: bitwise propagate/generate on a and ~b, then the span-1 prefix level.
  always_comb begin
    logic [W1-1:0]   g_ext;
    logic [W1-1:0]   p_ext;
    logic [2*W1-1:0] lvl;
    s1_p_d = bus.a ^ ~bus.b;
    g_ext  = {bus.a & ~bus.b, ~bus.bin};
    // Carry-in node has no propagate, so groups reaching it are fully resolved.
    p_ext  = {s1_p_d, 1'b0};
    lvl     = ks_level(g_ext, p_ext, 1);
    s1_g_d  = lvl[2*W1-1:W1];
    s1_pp_d = lvl[W1-1:0];
  end

  // Stage 2: remaining prefix levels, sum and flags.
  always_comb begin
    logic [W1-1:0]   g_cur;
    logic [W1-1:0]   p_cur;
    logic [2*W1-1:0] lvl;
    g_cur = s1_g_q;
    p_cur = s1_pp_q;
    for (int unsigned span = 2; span < W1; span = span * 2) begin
      lvl   = ks_level(g_cur, p_cur, span);
      g_cur = lvl[2*W1-1:W1];
      p_cur = lvl[W1-1:0];
    end
    // g_cur[j] is the carry into operand bit j; g_cur[WIDTH] is the carry-out.
    s2_d_d    = s1_p_q ^ g_cur[WIDTH-1:0];
    s2_bout_d = ~g_cur[WIDTH];
    s2_zero_d = (s2_d_d == '0);
    s2_ovf_d  = (s1_a_msb_q != s1_b_msb_q) && (s2_d_d[WIDTH-1] != s1_a_msb_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
    end else if (s1_load) begin
      s1_valid_q <= 1'b1;
    end else if (s2_load) begin
      s1_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (s1_load) begin
      s1_p_q     <= s1_p_d;
      s1_g_q     <= s1_g_d;
      s1_pp_q    <= s1_pp_d;
      s1_a_msb_q <= bus.a[WIDTH-1];
      s1_b_msb_q <= bus.b[WIDTH-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_d_q     <= '0;
      s2_bout_q  <= 1'b0;
      s2_zero_q  <= 1'b0;
      s2_ovf_q   <= 1'b0;
    end else if (s2_load) begin
      s2_valid_q <= 1'b1;
      s2_d_q     <= s2_d_d;
      s2_bout_q  <= s2_bout_d;
      s2_zero_q  <= s2_zero_d;
      s2_ovf_q   <= s2_ovf_d;
    end else if (bus.out_ready) begin
      s2_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = s2_valid_q;
  assign bus.d         = s2_d_q;
  assign bus.bout      = s2_bout_q;
  assign bus.zero      = s2_zero_q;
  assign bus.ovf       = s2_ovf_q;

endmodule

// File: tb/tb_ppa_sub_7.sv
// Directed/table-driven bench for ppa_sub_7 (WIDTH = 7).
module tb_ppa_sub_7;

  typedef struct {
    logic [6:0] a;
    logic [6:0] b;
    logic       bin;
    logic [6:0] d;
    logic       bout;
    logic       zero;
    logic       ovf;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  ppa_sub_7_if #(.WIDTH(7)) bus ();

  ppa_sub_7 #(.WIDTH(7)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: {d, bout, zero, ovf}.
  function automatic logic [9:0] model(input logic [6:0] a, input logic [6:0] b,
                                       input logic bin);
    logic [7:0] diff;
    logic [6:0] dd;
    diff = {1'b0, a} - {1'b0, b} - {7'd0, bin};
    dd   = diff[6:0];
    return {dd, diff[7], dd == 7'd0, (a[6] != b[6]) && (dd[6] != a[6])};
  endfunction

  function automatic logic [9:0] dut_res();
    return {bus.d, bus.bout, bus.zero, bus.ovf};
  endfunction

  task automatic drive(input logic [6:0] a, input logic [6:0] b, input logic bin);
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.bin      = bin;
  endtask

  // Push one item (already driven) and measure edges until out_valid rises.
  task automatic push_and_wait(input string name, output int lat);
    lat = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      bus.in_valid = 1'b0;
      if (bus.out_valid) begin
        lat = k + 1;
        break;
      end
    end
    check({name, "_latency"}, lat, 2);
  endtask

  vec_t       vecs[12];
  logic [9:0] exp_q[$];
  logic [9:0] exp_bp[3];
  int         lat;

  initial begin
    vecs[0]  = '{7'h05, 7'h03, 1'b0, 7'h02, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{7'h00, 7'h01, 1'b0, 7'h7F, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{7'h2A, 7'h2A, 1'b0, 7'h00, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{7'h2A, 7'h2A, 1'b1, 7'h7F, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{7'h40, 7'h01, 1'b0, 7'h3F, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{7'h3F, 7'h7F, 1'b0, 7'h40, 1'b1, 1'b0, 1'b1};
    vecs[6]  = '{7'h7F, 7'h00, 1'b0, 7'h7F, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{7'h00, 7'h7F, 1'b0, 7'h01, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{7'h00, 7'h00, 1'b1, 7'h7F, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{7'h7F, 7'h7F, 1'b1, 7'h7F, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{7'h10, 7'h05, 1'b1, 7'h0A, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{7'h40, 7'h7F, 1'b0, 7'h41, 1'b1, 1'b0, 1'b0};

    // Reset.
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.bin       = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_in_ready", bus.in_ready, 1);
    check("reset_fields", dut_res(), 0);

    // Table: one item at a time, latency and all fields.
    bus.out_ready = 1'b1;
    foreach (vecs[i]) begin
      drive(vecs[i].a, vecs[i].b, vecs[i].bin);
      #1;
      check($sformatf("vec%0d_in_ready", i), bus.in_ready, 1);
      push_and_wait($sformatf("vec%0d", i), lat);
      check($sformatf("vec%0d_d", i), bus.d, vecs[i].d);
      check($sformatf("vec%0d_bout", i), bus.bout, vecs[i].bout);
      check($sformatf("vec%0d_zero", i), bus.zero, vecs[i].zero);
      check($sformatf("vec%0d_ovf", i), bus.ovf, vecs[i].ovf);
    end
    tick();
    check("drain_out_valid", bus.out_valid, 0);

    // Backpressure: three items offered while the consumer is stalled.
    bus.out_ready = 1'b0;
    exp_bp[0] = model(7'h11, 7'h22, 1'b0);
    exp_bp[1] = model(7'h70, 7'h0F, 1'b1);
    exp_bp[2] = model(7'h33, 7'h33, 1'b0);
    drive(7'h11, 7'h22, 1'b0);
    #1;
    check("bp_ready0", bus.in_ready, 1);
    tick();
    drive(7'h70, 7'h0F, 1'b1);
    #1;
    check("bp_ready1", bus.in_ready, 1);
    tick();
    drive(7'h33, 7'h33, 1'b0);
    #1;
    check("bp_ready2_blocked", bus.in_ready, 0);
    check("bp_out_valid", bus.out_valid, 1);
    check("bp_hold0", dut_res(), exp_bp[0]);
    tick();
    check("bp_hold1", dut_res(), exp_bp[0]);
    check("bp_still_blocked", bus.in_ready, 0);
    // Release: drain, move and accept all in one edge.
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_ready", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    check("bp_out1_valid", bus.out_valid, 1);
    check("bp_out1", dut_res(), exp_bp[1]);
    tick();
    check("bp_out2_valid", bus.out_valid, 1);
    check("bp_out2", dut_res(), exp_bp[2]);
    tick();
    check("bp_empty", bus.out_valid, 0);

    // Full-rate random stream with scoreboard.
    begin
      int sent  = 0;
      int recv  = 0;
      int first = -1;
      int last  = -1;
      for (int cyc = 0; cyc < 200 && recv < 64; cyc++) begin
        if (sent < 64) begin
          drive(7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)),
                1'($urandom_range(0, 1)));
        end else begin
          bus.in_valid = 1'b0;
        end
        #1;
        if (bus.out_valid) begin
          if (exp_q.size() == 0) begin
            check("stream_unexpected", 1, 0);
          end else begin
            check($sformatf("stream%0d", recv), dut_res(), exp_q.pop_front());
          end
          recv++;
          if (first < 0) first = cyc;
          last = cyc;
        end
        if (bus.in_valid && bus.in_ready) begin
          exp_q.push_back(model(bus.a, bus.b, bus.bin));
          sent++;
        end
        tick();
      end
      bus.in_valid = 1'b0;
      check("stream_count", recv, 64);
      check("stream_rate", last - first, 63);
    end

    // Reset with both stages full.
    bus.out_ready = 1'b0;
    drive(7'h01, 7'h02, 1'b0);
    tick();
    drive(7'h55, 7'h11, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    #1;
    check("mid_full", {bus.out_valid, bus.in_ready}, 2'b10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_in_ready", bus.in_ready, 1);
    check("mid_rst_d", bus.d, 0);
    bus.out_ready = 1'b1;
    drive(7'h09, 7'h04, 1'b1);
    push_and_wait("post_rst", lat);
    check("post_rst_res", dut_res(), {7'h04, 1'b0, 1'b0, 1'b0});
    tick();
    check("post_rst_no_ghost", bus.out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
